multiboot_hotkey_req: RTL and testbench
=======================================

Name: multiboot_hotkey_req

Overview:
- Upstream request stage for the ICAP multiboot sequencer.
- Decodes the PS/2 set-2 scancode stream from the keyboard front end and tracks the Ctrl and Alt modifiers.
- On a reboot hotkey, or on an external request, it latches a 24-bit SPI flash address and emits a clean boot pulse.
- The sequencer consumes `boot` and `spi_addr`, and fires on the falling edge of `boot`.

Parameters:
- ADDR_SLOT0, 24'h000000, flash address for Ctrl+Alt+Backspace (core menu)
- ADDR_SLOT1, 24'h058000, flash address for Ctrl+Alt+F1
- ADDR_SLOT2, 24'h0B0000, flash address for Ctrl+Alt+F2
- ADDR_SLOT3, 24'h108000, flash address for Ctrl+Alt+F3
- ADDR_SLOT4, 24'h160000, flash address for Ctrl+Alt+F4
- PULSE_LEN, 16, cycles `boot` is held high (valid range 2..65535)
- HOLDOFF, 1000000, cycles after the pulse during which all requests are ignored (20-bit counter)

Ports:
- clk  in  1  system clock, same clock as the downstream sequencer, ≤20 MHz
- rst_n  in  1  asynchronous active-low reset
- scancode  in  8  PS/2 byte from the keyboard receiver
- scancode_valid  in  1  one-cycle strobe; `scancode` is valid this cycle
- ext_req  in  1  one-cycle external reboot request (e.g. from the OSD)
- ext_addr  in  24  flash address used with `ext_req`
- boot  out  1  registered boot pulse to the sequencer
- spi_addr  out  24  registered flash address; stable from pulse start until the next accepted request
- slot  out  3  0..4 = hotkey slot taken, 7 = external request
- busy  out  1  high in every state except IDLE

Behaviour:

Reset (rst_n=0, async):
- boot=0, spi_addr=ADDR_SLOT0, slot=0, busy=0.
- All modifier and prefix flags cleared; FSM in IDLE; counters cleared.
- Reset during PULSE drops `boot` to 0. The sequencer sees this as a falling edge and may reboot. This is accepted behaviour and is not masked.

Scancode decode (active in every state, only when scancode_valid=1):
- 8'hE0 sets the e0 flag. 8'hF0 sets the brk flag. 8'hE1 is ignored and the flags are unchanged.
- Any other byte is a key code. It is evaluated with the current e0/brk, then both flags clear in the same cycle.
- Key code 8'h14 updates lctrl (e0=0) or rctrl (e0=1).
- Key code 8'h11 updates lalt (e0=0) or ralt (e0=1).
- For both: set on make (brk=0), clear on break (brk=1).
- ctrl_any = lctrl|rctrl; alt_any = lalt|ralt.
- A trigger is a make code with e0=0, ctrl_any=1 and alt_any=1, where ctrl_any/alt_any are the values before this byte:
  - 8'h66 → slot 0
  - 8'h05 → slot 1
  - 8'h06 → slot 2
  - 8'h04 → slot 3
  - 8'h0C → slot 4
- Any other key code is not a trigger.

FSM:
- IDLE:
  - ext_req=1: latch ext_addr, slot=7, go to WAIT_REL.
  - Else on a trigger: latch ADDR_SLOTn, slot=n, go to WAIT_REL.
  - ext_req wins if both occur in the same cycle.
  - The latch and transition happen on the clock edge of the request; busy=1 from the next cycle.
- WAIT_REL:
  - Stay until ctrl_any=0 and alt_any=0, so the new core does not boot with modifiers held.
  - The cycle the condition is seen true, go to PULSE. This takes at least one cycle, even if the condition is already true on entry.
- PULSE:
  - boot=1 for exactly PULSE_LEN consecutive cycles, counted by a 16-bit down-counter.
  - Then boot=0 and go to HOLD.
- HOLD:
  - boot=0 for HOLDOFF cycles, then go to IDLE.
  - Gives ≥3 low cycles for the sequencer edge detector and blocks key-repeat retriggers.
- Requests and triggers arriving in any state other than IDLE are dropped, not queued. Modifier tracking continues in all states.
- spi_addr and slot change only on an accepted request in IDLE.

Test Plan:
- Bytes 14, 11, 66, then F0 66, F0 11, F0 14 → slot=0, spi_addr=000000; boot rises only after the F0 14 byte, stays high 16 cycles, then low; busy returns to 0 exactly HOLDOFF cycles after the fall.
- Bytes E0 14, E0 11, 05, then E0 F0 14, E0 F0 11 → slot=1, spi_addr=058000, one 16-cycle pulse.
- ext_req=1 with ext_addr=2A0000 in the same cycle as the trigger byte 0C (Ctrl+Alt held) → slot=7, spi_addr=2A0000.
- Byte 66 with only Ctrl held, and E0 66 with Ctrl+Alt held → no request, busy stays 0.
- Trigger accepted, then a repeated 06 make during WAIT_REL and HOLD → exactly one pulse; spi_addr unchanged.
- rst_n low mid-PULSE → boot=0 immediately (async), FSM in IDLE, all modifier flags cleared.

Source files
------------

// File: rtl/multiboot_hotkey_req.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multiboot_hotkey_req - PS/2 reboot hotkey / external request to boot pulse
// Rev 1.0
// ----------------------------------------------------------------------------
module multiboot_hotkey_req #(
  parameter logic [23:0] ADDR_SLOT0 = 24'h000000,
  parameter logic [23:0] ADDR_SLOT1 = 24'h058000,
  parameter logic [23:0] ADDR_SLOT2 = 24'h0B0000,
  parameter logic [23:0] ADDR_SLOT3 = 24'h108000,
  parameter logic [23:0] ADDR_SLOT4 = 24'h160000,
  parameter int unsigned PULSE_LEN  = 16,
  parameter int unsigned HOLDOFF    = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  scancode_i,
  input  logic        scancode_valid_i,
  input  logic        ext_req_i,
  input  logic [23:0] ext_addr_i,
  output logic        boot_o,
  output logic [23:0] spi_addr_o,
  output logic [2:0]  slot_o,
  output logic        busy_o
);

  localparam logic [15:0] c_pulse_load = 16'(PULSE_LEN - 1);
  localparam logic [19:0] c_hold_load  = (HOLDOFF > 0) ? 20'(HOLDOFF - 1) : 20'd0;
  localparam logic [2:0]  c_slot_ext   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_REL = 2'd1,
    S_PULSE    = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        e0_q, e0_d;
  logic        brk_q, brk_d;
  logic        lctrl_q, lctrl_d;
  logic        rctrl_q, rctrl_d;
  logic        lalt_q, lalt_d;
  logic        ralt_q, ralt_d;
  logic [15:0] pulse_cnt_q, pulse_cnt_d;
  logic [19:0] hold_cnt_q, hold_cnt_d;
  logic [23:0] spi_addr_q, spi_addr_d;
  logic [2:0]  slot_q, slot_d;
  logic        boot_q, boot_d;

  logic        w_is_e0;
  logic        w_is_f0;
  logic        w_is_key;
  logic        w_ctrl_any;
  logic        w_alt_any;
  logic        w_hit;
  logic [2:0]  w_hit_slot;
  logic [23:0] w_hit_addr;
  logic        w_trigger;

  always_comb begin
    w_is_e0    = scancode_valid_i && (scancode_i == 8'hE0);
    w_is_f0    = scancode_valid_i && (scancode_i == 8'hF0);
    w_is_key   = scancode_valid_i && (scancode_i != 8'hE0) &&
                 (scancode_i != 8'hF0) && (scancode_i != 8'hE1);
    w_ctrl_any = lctrl_q | rctrl_q;
    w_alt_any  = lalt_q | ralt_q;

    w_hit      = 1'b0;
    w_hit_slot = 3'd0;
    w_hit_addr = ADDR_SLOT0;
    case (scancode_i)
      8'h66: begin w_hit = 1'b1; w_hit_slot = 3'd0; w_hit_addr = ADDR_SLOT0; end
      8'h05: begin w_hit = 1'b1; w_hit_slot = 3'd1; w_hit_addr = ADDR_SLOT1; end
      8'h06: begin w_hit = 1'b1; w_hit_slot = 3'd2; w_hit_addr = ADDR_SLOT2; end
      8'h04: begin w_hit = 1'b1; w_hit_slot = 3'd3; w_hit_addr = ADDR_SLOT3; end
      8'h0C: begin w_hit = 1'b1; w_hit_slot = 3'd4; w_hit_addr = ADDR_SLOT4; end
      default: ;
    endcase

    // Modifier state is the value before this byte, so Ctrl/Alt make codes never self-trigger.
    w_trigger = w_is_key && !e0_q && !brk_q && w_ctrl_any && w_alt_any && w_hit;
  end

  always_comb begin
    e0_d    = e0_q;
    brk_d   = brk_q;
    lctrl_d = lctrl_q;
    rctrl_d = rctrl_q;
    lalt_d  = lalt_q;
    ralt_d  = ralt_q;
    if (w_is_e0) begin
      e0_d = 1'b1;
    end else if (w_is_f0) begin
      brk_d = 1'b1;
    end else if (w_is_key) begin
      e0_d  = 1'b0;
      brk_d = 1'b0;
      if (scancode_i == 8'h14) begin
        if (e0_q) rctrl_d = !brk_q;
        else      lctrl_d = !brk_q;
      end else if (scancode_i == 8'h11) begin
        if (e0_q) ralt_d = !brk_q;
        else      lalt_d = !brk_q;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    spi_addr_d  = spi_addr_q;
    slot_d      = slot_q;
    case (state_q)
      S_IDLE: begin
        if (ext_req_i) begin
          spi_addr_d = ext_addr_i;
          slot_d     = c_slot_ext;
          state_d    = S_WAIT_REL;
        end else if (w_trigger) begin
          spi_addr_d = w_hit_addr;
          slot_d     = w_hit_slot;
          state_d    = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (!w_ctrl_any && !w_alt_any) begin
          state_d     = S_PULSE;
          pulse_cnt_d = c_pulse_load;
        end
      end
      S_PULSE: begin
        if (pulse_cnt_q == 16'd0) begin
          state_d    = S_HOLD;
          hold_cnt_d = c_hold_load;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 16'd1;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == 20'd0) begin
          state_d = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    boot_d = (state_d == S_PULSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      e0_q        <= 1'b0;
      brk_q       <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      pulse_cnt_q <= 16'd0;
      hold_cnt_q  <= 20'd0;
      spi_addr_q  <= ADDR_SLOT0;
      slot_q      <= 3'd0;
      boot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      e0_q        <= e0_d;
      brk_q       <= brk_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      lalt_q      <= lalt_d;
      ralt_q      <= ralt_d;
      pulse_cnt_q <= pulse_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      spi_addr_q  <= spi_addr_d;
      slot_q      <= slot_d;
      boot_q      <= boot_d;
    end
  end

  assign boot_o     = boot_q;
  assign spi_addr_o = spi_addr_q;
  assign slot_o     = slot_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multiboot_hotkey_req.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multiboot_hotkey_req - directed scoreboard bench for multiboot_hotkey_req
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_multiboot_hotkey_req;

  localparam int unsigned c_pulse = 16;
  localparam int unsigned c_hold  = 40;

  logic        clk;
  logic        rst_n;
  logic [7:0]  scancode;
  logic        scancode_valid;
  logic        ext_req;
  logic [23:0] ext_addr;
  logic        boot;
  logic [23:0] spi_addr;
  logic [2:0]  slot;
  logic        busy;

  typedef struct packed {
    logic [2:0]  slot;
    logic [23:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pulses = 0;

  multiboot_hotkey_req #(
    .PULSE_LEN (c_pulse),
    .HOLDOFF   (c_hold)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .scancode_i       (scancode),
    .scancode_valid_i (scancode_valid),
    .ext_req_i        (ext_req),
    .ext_addr_i       (ext_addr),
    .boot_o           (boot),
    .spi_addr_o       (spi_addr),
    .slot_o           (slot),
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: pops the scoreboard on each rising boot, times high and holdoff phases.
  logic prev_boot = 1'b0;
  int   high_cnt  = 0;
  int   hold_cnt  = 0;
  bit   in_hold   = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_boot = 1'b0;
      high_cnt  = 0;
      hold_cnt  = 0;
      in_hold   = 1'b0;
    end else begin
      if (boot && !prev_boot) begin
        n_pulses++;
        high_cnt = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_slot", 32'(slot), 32'(e.slot));
          check("pulse_addr", 32'(spi_addr), 32'(e.addr));
        end
      end else if (boot) begin
        high_cnt++;
      end else if (prev_boot) begin
        check("pulse_len", 32'(high_cnt), 32'(c_pulse));
        in_hold  = 1'b1;
        hold_cnt = 0;
      end
      if (in_hold && !boot) begin
        if (busy) begin
          hold_cnt++;
        end else begin
          check("holdoff_len", 32'(hold_cnt), 32'(c_hold));
          in_hold = 1'b0;
        end
      end
      prev_boot = boot;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scancode       = b;
    scancode_valid = 1'b1;
    @(negedge clk);
    scancode_valid = 1'b0;
  endtask

  task automatic wait_boot_level(input logic lvl, input string tag);
    int n = 0;
    while (boot !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (boot !== lvl) check(tag, 32'(boot), 32'(lvl));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int base;
    rst_n          = 1'b0;
    scancode       = 8'h00;
    scancode_valid = 1'b0;
    ext_req        = 1'b0;
    ext_addr       = 24'h0;
    idle_cycles(3);
    check("rst_boot", 32'(boot), 32'd0);
    check("rst_addr", 32'(spi_addr), 32'h000000);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Ctrl+Alt+Backspace, left modifiers
    send_byte(8'h14);
    send_byte(8'h11);
    exp_q.push_back('{slot: 3'd0, addr: 24'h000000});
    send_byte(8'h66);
    check("t1_busy_after_trig", 32'(busy), 32'd1);
    send_byte(8'hF0); send_byte(8'h66);
    send_byte(8'hF0); send_byte(8'h11);
    check("t1_boot_held_mods", 32'(boot), 32'd0);
    send_byte(8'hF0); send_byte(8'h14);
    wait_boot_level(1'b1, "t1_boot_rise_timeout");
    wait_idle("t1_idle");
    check("t1_pulses", 32'(n_pulses), 32'd1);

    // Ctrl+Alt+F1, right modifiers
    send_byte(8'hE0); send_byte(8'h14);
    send_byte(8'hE0); send_byte(8'h11);
    exp_q.push_back('{slot: 3'd1, addr: 24'h058000});
    send_byte(8'h05);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h11);
    wait_boot_level(1'b1, "t2_boot_rise_timeout");
    wait_idle("t2_idle");
    check("t2_pulses", 32'(n_pulses), 32'd2);

    // External request collides with an F4 trigger; external wins
    send_byte(8'h14);
    send_byte(8'h11);
    @(negedge clk);
    scancode       = 8'h0C;
    scancode_valid = 1'b1;
    ext_req        = 1'b1;
    ext_addr       = 24'h2A0000;
    exp_q.push_back('{slot: 3'd7, addr: 24'h2A0000});
    @(negedge clk);
    scancode_valid = 1'b0;
    ext_req        = 1'b0;
    send_byte(8'hF0); send_byte(8'h11);
    send_byte(8'hF0); send_byte(8'h14);
    wait_boot_level(1'b1, "t3_boot_rise_timeout");
    wait_idle("t3_idle");
    check("t3_slot_after", 32'(slot), 32'd7);
    check("t3_addr_after", 32'(spi_addr), 32'h2A0000);

    // Non-triggers: Ctrl only, and extended 66 with Ctrl+Alt
    send_byte(8'h14);
    send_byte(8'h66);
    idle_cycles(2);
    check("t4_ctrl_only_busy", 32'(busy), 32'd0);
    send_byte(8'h11);
    send_byte(8'hE0); send_byte(8'h66);
    idle_cycles(2);
    check("t4_e0_busy", 32'(busy), 32'd0);
    send_byte(8'hF0); send_byte(8'h11);
    send_byte(8'hF0); send_byte(8'h14);
    check("t4_pulses", 32'(n_pulses), 32'd3);

    // Repeated F2 make during WAIT_REL, PULSE and HOLD yields one pulse
    base = n_pulses;
    send_byte(8'h14);
    send_byte(8'h11);
    exp_q.push_back('{slot: 3'd2, addr: 24'h0B0000});
    send_byte(8'h06);
    send_byte(8'h06);
    send_byte(8'hF0); send_byte(8'h11);
    send_byte(8'hF0); send_byte(8'h14);
    wait_boot_level(1'b1, "t5_boot_rise_timeout");
    send_byte(8'h14); send_byte(8'h11); send_byte(8'h06);
    send_byte(8'hF0); send_byte(8'h11);
    send_byte(8'hF0); send_byte(8'h14);
    wait_boot_level(1'b0, "t5_boot_fall_timeout");
    send_byte(8'h14); send_byte(8'h11); send_byte(8'h06);
    @(negedge clk);
    ext_req  = 1'b1;
    ext_addr = 24'h123456;
    @(negedge clk);
    ext_req  = 1'b0;
    send_byte(8'hF0); send_byte(8'h11);
    send_byte(8'hF0); send_byte(8'h14);
    wait_idle("t5_idle");
    idle_cycles(4);
    check("t5_one_pulse", 32'(n_pulses - base), 32'd1);
    check("t5_addr_kept", 32'(spi_addr), 32'h0B0000);
    check("t5_slot_kept", 32'(slot), 32'd2);

    // Async reset mid-pulse with modifiers held
    send_byte(8'h14);
    send_byte(8'h11);
    exp_q.push_back('{slot: 3'd1, addr: 24'h058000});
    send_byte(8'h05);
    send_byte(8'hF0); send_byte(8'h11);
    send_byte(8'hF0); send_byte(8'h14);
    wait_boot_level(1'b1, "t6_boot_rise_timeout");
    send_byte(8'h14);
    send_byte(8'h11);
    check("t6_boot_mid_pulse", 32'(boot), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_boot", 32'(boot), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_addr", 32'(spi_addr), 32'h000000);
    check("t6_rst_slot", 32'(slot), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    send_byte(8'h66);
    idle_cycles(3);
    check("t6_mods_cleared", 32'(busy), 32'd0);
    check("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
